// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blank/drive dead time
// and frame-boundary double buffering of the display data.
module seg7_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_clk,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  load,
  output logic                  pending,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  typedef enum logic {BLANK, DRIVE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_DIGITS - 1);

  logic s1, s2, s3, tick;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*N_DIGITS-1:0] sh_val_q, sh_val_d, ac_val_q, ac_val_d;
  logic [N_DIGITS-1:0]  sh_dp_q, sh_dp_d, ac_dp_q, ac_dp_d;
  logic [N_DIGITS-1:0]  sh_bl_q, sh_bl_d, ac_bl_q, ac_bl_d;
  logic                 pending_d;
  logic [N_DIGITS-1:0]  an_d;
  logic [6:0]           seg_d;
  logic                 dp_d, fs_d;
  logic [3:0]           nib;

  function automatic logic [6:0] dec7(input logic [3:0] h);
    logic [6:0] s;
    s = 7'b1111111;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // scan_clk is asynchronous: two-flop sync, then rising-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= scan_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;
  assign nib  = ac_val_q[4*idx_q +: 4];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    sh_bl_d   = sh_bl_q;
    ac_val_d  = ac_val_q;
    ac_dp_d   = ac_dp_q;
    ac_bl_d   = ac_bl_q;
    pending_d = pending;
    an_d      = an;
    seg_d     = seg;
    dp_d      = dp;
    fs_d      = 1'b0;
    if (tick) begin
      case (state_q)
        BLANK: begin
          state_d = DRIVE;
          an_d    = '1;
          if (!ac_bl_q[idx_q]) an_d[idx_q] = 1'b0;
          seg_d   = dec7(nib);
          dp_d    = ~ac_dp_q[idx_q];
        end
        DRIVE: begin
          state_d = BLANK;
          an_d    = '1;
          seg_d   = 7'b1111111;
          dp_d    = 1'b1;
          if (idx_q == LAST) begin
            idx_d = '0;
            fs_d  = 1'b1;
            if (pending) begin
              ac_val_d  = sh_val_q;
              ac_dp_d   = sh_dp_q;
              ac_bl_d   = sh_bl_q;
              pending_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = BLANK;
      endcase
    end
    // a load in the apply cycle lands after the copy and stays pending
    if (load) begin
      sh_val_d  = value_in;
      sh_dp_d   = dp_in;
      sh_bl_d   = blank_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BLANK;
      idx_q       <= '0;
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_bl_q     <= '1;
      ac_val_q    <= '0;
      ac_dp_q     <= '0;
      ac_bl_q     <= '1;
      pending     <= 1'b0;
      an          <= '1;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sh_val_q    <= sh_val_d;
      sh_dp_q     <= sh_dp_d;
      sh_bl_q     <= sh_bl_d;
      ac_val_q    <= ac_val_d;
      ac_dp_q     <= ac_dp_d;
      ac_bl_q     <= ac_bl_d;
      pending     <= pending_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: tick-count display model checked every
// cycle, plus literal expectations from hand-worked scan sequences.
module tb_seg7_scan_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          scan_clk;
  logic [15:0]   value_in;
  logic [3:0]    dp_in;
  logic [3:0]    blank_in;
  logic          load;
  logic          pending;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_start;

  seg7_scan_ctrl #(.N_DIGITS(4), .IDX_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .scan_clk(scan_clk),
    .value_in(value_in),
    .dp_in(dp_in),
    .blank_in(blank_in),
    .load(load),
    .pending(pending),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] dec [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;

  int          k;
  logic [15:0] a_val, sh_val;
  logic [3:0]  a_dp, sh_dp, a_bl, sh_bl;
  bit          mpend, mfs;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    k      = 0;
    a_val  = '0;
    a_dp   = '0;
    a_bl   = '1;
    sh_val = '0;
    sh_dp  = '0;
    sh_bl  = '1;
    mpend  = 0;
    mfs    = 0;
  endfunction

  // Tick k odd: digit ((k-1)/2) mod N is lit; tick k even: dark gap.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      int d;
      e_an  = 4'b1111;
      e_seg = 7'b1111111;
      e_dp  = 1'b1;
      if (k % 2 == 1) begin
        d     = ((k - 1) / 2) % N;
        e_seg = dec[a_val[4*d +: 4]];
        e_dp  = ~a_dp[d];
        if (!a_bl[d]) e_an = ~(4'b0001 << d);
      end
      chk("an", {4'b0, an}, {4'b0, e_an});
      chk("seg", {1'b0, seg}, {1'b0, e_seg});
      chk("dp", {7'b0, dp}, {7'b0, e_dp});
      chk("pending", {7'b0, pending}, {7'b0, mpend});
      chk("frame_start", {7'b0, frame_start}, {7'b0, mfs});
    end
  end

  task automatic tick1();
    @(negedge clk);
    scan_clk = 1'b1;
    repeat (3) @(posedge clk);
    k++;
    mfs = (k % (2 * N) == 0);
    if (mfs && mpend) begin
      a_val = sh_val;
      a_dp  = sh_dp;
      a_bl  = sh_bl;
      mpend = 0;
    end
    @(posedge clk);
    mfs = 0;
    @(negedge clk);
    scan_clk = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick1();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] b);
    @(negedge clk);
    value_in = v;
    dp_in    = d;
    blank_in = b;
    load     = 1'b1;
    @(posedge clk);
    sh_val = v;
    sh_dp  = d;
    sh_bl  = b;
    mpend  = 1;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [3:0] an_t  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_t [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};

  initial begin
    rst      = 1'b1;
    scan_clk = 1'b0;
    value_in = '0;
    dp_in    = '0;
    blank_in = '0;
    load     = 1'b0;
    model_reset();
    #1;
    chk("rst_an", {4'b0, an}, 8'h0f);
    chk("rst_seg", {1'b0, seg}, 8'h7f);
    chk("rst_dp", {7'b0, dp}, 8'h01);
    chk("rst_pending", {7'b0, pending}, 8'h00);
    chk("rst_fs", {7'b0, frame_start}, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    chk_en = 1;

    run(16);
    chk("idle_pending", {7'b0, pending}, 8'h00);

    do_load(16'h12AF, 4'b0000, 4'b0000);
    chk("load_pending", {7'b0, pending}, 8'h01);
    run(8);
    chk("apply_pending", {7'b0, pending}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick1();
      chk("basic_an", {4'b0, an}, {4'b0, an_t[i]});
      chk("basic_seg", {1'b0, seg}, {1'b0, seg_t[i]});
      tick1();
      chk("basic_gap", {4'b0, an}, 8'h0f);
    end

    do_load(16'h0000, 4'b0000, 4'b0000);
    run(12);
    do_load(16'h8888, 4'b0000, 4'b0000);
    tick1();
    chk("tear_d2_seg", {1'b0, seg}, 8'h40);
    chk("tear_d2_an", {4'b0, an}, 8'h0b);
    run(2);
    chk("tear_d3_seg", {1'b0, seg}, 8'h40);
    run(2);
    chk("new_d0_seg", {1'b0, seg}, 8'h00);
    chk("new_d0_an", {4'b0, an}, 8'h0e);
    run(7);

    do_load(16'h1111, 4'b0000, 4'b0000);
    run(2);
    chk("ow_pending", {7'b0, pending}, 8'h01);
    do_load(16'h2222, 4'b0000, 4'b0000);
    run(6);
    chk("ow_cleared", {7'b0, pending}, 8'h00);
    tick1();
    chk("ow_seg", {1'b0, seg}, 8'h24);
    run(7);

    do_load(16'h5555, 4'b0001, 4'b0100);
    run(8);
    tick1();
    chk("bd_d0_dp", {7'b0, dp}, 8'h00);
    chk("bd_d0_seg", {1'b0, seg}, 8'h12);
    run(2);
    chk("bd_d1_dp", {7'b0, dp}, 8'h01);
    chk("bd_d1_an", {4'b0, an}, 8'h0d);
    run(2);
    chk("bd_d2_an", {4'b0, an}, 8'h0f);
    run(3);

    tick1();
    do_load(16'h3333, 4'b0000, 4'b0000);
    run(2);
    chk("pre_rst_an", {4'b0, an}, 8'h0d);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", {4'b0, an}, 8'h0f);
    chk("arst_seg", {1'b0, seg}, 8'h7f);
    chk("arst_dp", {7'b0, dp}, 8'h01);
    chk("arst_pending", {7'b0, pending}, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    run(16);
    chk("post_rst_pending", {7'b0, pending}, 8'h00);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
